mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage engine that consumes the EX/MEM pipeline register outputs and performs the data-memory access for loads and stores. It aligns store data with byte strobes, runs a valid/ready request plus response handshake to the data memory, and sign- or zero-extends load data. It stalls upstream while an access is outstanding and delivers one registered result per instruction to the MEM/WB register.

## Interface
- DATA_WIDTH, 64, data and address width
- REG_ADDR_WIDTH, 5, destination register index width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  unit accepts the instruction this cycle; low means stall upstream
- in_addr  in  DATA_WIDTH  ALU result: effective address, or result for non-memory ops
- in_store_data  in  DATA_WIDTH  val_b (rs2 value)
- in_mem_read / in_mem_write  in  1 each  load / store; both high is illegal and treated as load
- in_size  in  2  0=B, 1=H, 2=W, 3=D
- in_unsigned  in  1  zero-extend load
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_reg_write  in  1  writes rd
- req_valid  out  1  memory request
- req_ready  in  1  memory accepts request
- req_addr  out  DATA_WIDTH  doubleword-aligned address (in_addr with [2:0]=0)
- req_we  out  1  store
- req_wdata  out  DATA_WIDTH  store data shifted into byte lane
- req_wstrb  out  8  byte enables
- resp_valid  in  1  response (load data or store ack)
- resp_rdata  in  DATA_WIDTH  aligned doubleword
- wb_valid  out  1  result valid for MEM/WB (single-cycle pulse)
- wb_data  out  DATA_WIDTH  load result or passed-through ALU result
- wb_rd  out  REG_ADDR_WIDTH  destination register
- wb_reg_write  out  1  write enable, forced 0 on misalign
- wb_misalign  out  1  misaligned access exception

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: in_ready=1. On in_valid:
  - Non-memory op: register result and go to wb_valid next cycle; stay IDLE.
  - Misaligned op (addr[2:0] not a multiple of 2^size): no request; wb_valid with wb_misalign=1 and wb_reg_write=0; stay IDLE.
  - Otherwise: latch addr, size, unsigned, rd, reg_write, we, wdata, and wstrb; go to REQ.
- REQ: in_ready=0, req_valid=1, and request fields stay stable. On req_ready, go to WAIT.
- WAIT: in_ready=0, req_valid=0. On resp_valid, produce the result and go to IDLE.
- Load result:
  - Shift resp_rdata right by addr[2:0]*8.
  - Truncate to 8, 16, 32, or 64 bits.
  - Sign-extend unless unsigned; unsigned is ignored for D.
- Store:
  - req_wdata = in_store_data << (addr[2:0]*8), truncated to 64 bits.
  - req_wstrb = ((1<<(1<<size))-1) << addr[2:0].
  - wb_data = 0, wb_reg_write = 0.
- resp_valid outside WAIT is ignored. req_ready outside REQ is ignored.

## Timing
- Reset values: state=IDLE; in_ready=1; req_valid=0; req_we=0; req_addr, req_wdata, req_wstrb=0; wb_valid=0; wb_data=0; wb_rd=0; wb_reg_write=0; wb_misalign=0.
- Non-memory or misaligned op: wb_valid is asserted 1 cycle after acceptance.
- Memory op:
  - req_valid is asserted the cycle after acceptance.
  - wb_valid is asserted the cycle after resp_valid is sampled in WAIT.
  - Minimum latency is 3 cycles, with zero-wait req_ready and resp_valid on the first WAIT cycle.
- in_ready returns high in the same cycle wb_valid of a memory op asserts, so back-to-back accepts are allowed.
- Reset mid-access: return to IDLE next edge, drop req_valid, drop any pending response, and emit no wb_valid. The memory shares the same reset.

## Structure
- Package mem_pkg holds:
  - mem_size_e (MEM_B, MEM_H, MEM_W, MEM_D)
  - mem_state_e (IDLE, REQ, WAIT)
  - the mem_ctrl_t struct (mem_read, mem_write, size, unsigned, rd, reg_write), shared with the EX/MEM register
- Sub-module mem_load_align: combinational shift, truncate, and extend of resp_rdata, given addr[2:0], size, and unsigned.

## Test plan
- ALU op, addr=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, no req_valid.
- Load W signed at 0x1004, resp_rdata=0x80000000_00000000 -> req_addr=0x1000, wb_data=0xFFFFFFFF_80000000. The same access unsigned gives 0x00000000_80000000.
- Store H at 0x2006, data=0xABCD -> req_we=1, req_wstrb=0xC0, req_wdata=0xABCD_0000_0000_0000, wb_reg_write=0.
- Load H at 0x3001 -> wb_misalign=1, wb_reg_write=0, no req_valid, 1-cycle latency.
- Back-pressure: req_ready held low 4 cycles -> req_valid and fields held stable, in_ready=0 throughout, a single wb_valid pulse at the end.
- Reset asserted in WAIT, then resp_valid arrives -> no wb_valid, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: access sizes, FSM states and the EX/MEM control bundle.
package mem_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic             mem_read;
      logic             mem_write;
      mem_size_e        size;
      logic             is_unsigned;
      logic [REG_W-1:0] rd;
      logic             reg_write;
   } mem_ctrl_t;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(mem_size_e s);
      case (s)
         MEM_B:   return 3'b000;
         MEM_H:   return 3'b001;
         MEM_W:   return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] byte_strobe(mem_size_e s, logic [2:0] off);
      logic [7:0] base;
      case (s)
         MEM_B:   base = 8'h01;
         MEM_H:   base = 8'h03;
         MEM_W:   base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus; master is the memory stage, slave is the memory.
interface mem_access_unit_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_addr;
   logic                  req_we;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [7:0]            req_wstrb;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Extracts the addressed byte/half/word/double from an aligned doubleword and extends it.
module mem_load_align
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] i_rdata,
   input  logic [2:0]            i_offset,
   input  mem_size_e             i_size,
   input  logic                  i_unsigned,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [DATA_WIDTH-1:0] w_shifted;
   logic                  w_sign;

   assign w_shifted = i_rdata >> {i_offset, 3'b000};

   always_comb begin
      o_data = w_shifted;
      w_sign = 1'b0;
      case (i_size)
         MEM_B: begin
            w_sign = w_shifted[7] & ~i_unsigned;
            o_data = {{(DATA_WIDTH-8){w_sign}}, w_shifted[7:0]};
         end
         MEM_H: begin
            w_sign = w_shifted[15] & ~i_unsigned;
            o_data = {{(DATA_WIDTH-16){w_sign}}, w_shifted[15:0]};
         end
         MEM_W: begin
            w_sign = w_shifted[31] & ~i_unsigned;
            o_data = {{(DATA_WIDTH-32){w_sign}}, w_shifted[31:0]};
         end
         default: o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues one data-memory access per load/store, stalls upstream while it is
// outstanding, and hands a single-cycle registered result to MEM/WB.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_addr,
   input  logic [DATA_WIDTH-1:0]     in_store_data,
   input  logic                      in_mem_read,
   input  logic                      in_mem_write,
   input  logic [1:0]                in_size,
   input  logic                      in_unsigned,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic                      in_reg_write,
   mem_access_unit_if.master         mem,
   output logic                      wb_valid,
   output logic [DATA_WIDTH-1:0]     wb_data,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic                      wb_reg_write,
   output logic                      wb_misalign
);

   mem_state_e r_state, w_next_state;
   mem_ctrl_t  w_ctrl, r_ctrl;

   logic [2:0]            r_offset;
   logic [DATA_WIDTH-1:0] r_req_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [7:0]            r_wstrb;
   logic                  w_req_valid;
   logic                  w_is_mem;
   logic                  w_misalign;
   logic [DATA_WIDTH-1:0] w_load_data;

   logic                      r_wb_valid;
   logic [DATA_WIDTH-1:0]     r_wb_data;
   logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
   logic                      r_wb_reg_write;
   logic                      r_wb_misalign;

   assign w_ctrl.mem_read    = in_mem_read;
   assign w_ctrl.mem_write   = in_mem_write;
   assign w_ctrl.size        = mem_size_e'(in_size);
   assign w_ctrl.is_unsigned = in_unsigned;
   assign w_ctrl.rd          = in_rd;
   assign w_ctrl.reg_write   = in_reg_write;

   assign w_is_mem   = in_mem_read | in_mem_write;
   assign w_misalign = (in_addr[2:0] & align_mask(w_ctrl.size)) != 3'b000;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      w_req_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && w_is_mem && !w_misalign) w_next_state = REQ;
         end
         REQ: begin
            w_req_valid = 1'b1;
            if (mem.req_ready) w_next_state = WAIT;
         end
         WAIT: begin
            if (mem.resp_valid) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
      .i_rdata    (mem.resp_rdata),
      .i_offset   (r_offset),
      .i_size     (r_ctrl.size),
      .i_unsigned (r_ctrl.is_unsigned),
      .o_data     (w_load_data)
   );

   // Read wins when both read and write are set, so a store is write-without-read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl         <= '0;
         r_offset       <= '0;
         r_req_addr     <= '0;
         r_wdata        <= '0;
         r_wstrb        <= '0;
         r_wb_valid     <= 1'b0;
         r_wb_data      <= '0;
         r_wb_rd        <= '0;
         r_wb_reg_write <= 1'b0;
         r_wb_misalign  <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (!w_is_mem) begin
                     r_wb_valid     <= 1'b1;
                     r_wb_data      <= in_addr;
                     r_wb_rd        <= in_rd;
                     r_wb_reg_write <= in_reg_write;
                     r_wb_misalign  <= 1'b0;
                  end else if (w_misalign) begin
                     r_wb_valid     <= 1'b1;
                     r_wb_data      <= '0;
                     r_wb_rd        <= in_rd;
                     r_wb_reg_write <= 1'b0;
                     r_wb_misalign  <= 1'b1;
                  end else begin
                     r_ctrl     <= w_ctrl;
                     r_offset   <= in_addr[2:0];
                     r_req_addr <= {in_addr[DATA_WIDTH-1:3], 3'b000};
                     if (in_mem_write && !in_mem_read) begin
                        r_wdata <= in_store_data << {in_addr[2:0], 3'b000};
                        r_wstrb <= byte_strobe(w_ctrl.size, in_addr[2:0]);
                     end else begin
                        r_wdata <= '0;
                        r_wstrb <= '0;
                     end
                  end
               end
            end
            WAIT: begin
               if (mem.resp_valid) begin
                  r_wb_valid     <= 1'b1;
                  r_wb_data      <= r_ctrl.mem_read ? w_load_data : '0;
                  r_wb_rd        <= r_ctrl.rd;
                  r_wb_reg_write <= r_ctrl.mem_read & r_ctrl.reg_write;
                  r_wb_misalign  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.req_valid = w_req_valid;
   assign mem.req_addr  = r_req_addr;
   assign mem.req_we    = r_ctrl.mem_write & ~r_ctrl.mem_read;
   assign mem.req_wdata = r_wdata;
   assign mem.req_wstrb = r_wstrb;

   assign wb_valid     = r_wb_valid;
   assign wb_data      = r_wb_data;
   assign wb_rd        = r_wb_rd;
   assign wb_reg_write = r_wb_reg_write;
   assign wb_misalign  = r_wb_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expected values.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_addr;
   logic [63:0] in_store_data;
   logic        in_mem_read;
   logic        in_mem_write;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        wb_valid;
   logic [63:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_misalign;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   mem_access_unit_if #(.DATA_WIDTH(64)) memif ();

   mem_access_unit #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_addr       (in_addr),
      .in_store_data (in_store_data),
      .in_mem_read   (in_mem_read),
      .in_mem_write  (in_mem_write),
      .in_size       (in_size),
      .in_unsigned   (in_unsigned),
      .in_rd         (in_rd),
      .in_reg_write  (in_reg_write),
      .mem           (memif),
      .wb_valid      (wb_valid),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_misalign   (wb_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"},     64'(in_ready), 64'd1);
      check({tag, " req_valid"},    64'(memif.req_valid), 64'd0);
      check({tag, " req_we"},       64'(memif.req_we), 64'd0);
      check({tag, " req_addr"},     memif.req_addr, 64'd0);
      check({tag, " req_wdata"},    memif.req_wdata, 64'd0);
      check({tag, " req_wstrb"},    64'(memif.req_wstrb), 64'd0);
      check({tag, " wb_valid"},     64'(wb_valid), 64'd0);
      check({tag, " wb_data"},      wb_data, 64'd0);
      check({tag, " wb_rd"},        64'(wb_rd), 64'd0);
      check({tag, " wb_reg_write"}, 64'(wb_reg_write), 64'd0);
      check({tag, " wb_misalign"},  64'(wb_misalign), 64'd0);
   endtask

   task automatic drive(input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic [1:0] size,
                        input logic uns, input logic rw);
      in_addr       = addr;
      in_store_data = sdata;
      in_rd         = rd;
      in_mem_read   = mr;
      in_mem_write  = mw;
      in_size       = size;
      in_unsigned   = uns;
      in_reg_write  = rw;
      in_valid      = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic do_alu(input string tag, input logic [63:0] addr, input logic [4:0] rd,
                         input logic rw);
      drive(addr, 64'h0, rd, 1'b0, 1'b0, 2'd3, 1'b0, rw);
      @(negedge clk);
      check({tag, " wb_valid"},     64'(wb_valid), 64'd1);
      check({tag, " wb_data"},      wb_data, addr);
      check({tag, " wb_rd"},        64'(wb_rd), 64'(rd));
      check({tag, " wb_reg_write"}, 64'(wb_reg_write), 64'(rw));
      check({tag, " wb_misalign"},  64'(wb_misalign), 64'd0);
      check({tag, " req_valid"},    64'(memif.req_valid), 64'd0);
      @(negedge clk);
      check({tag, " pulse"},        64'(wb_valid), 64'd0);
   endtask

   task automatic do_misalign(input string tag, input logic [63:0] addr, input logic mr,
                              input logic mw, input logic [1:0] size, input logic [4:0] rd);
      drive(addr, 64'h0, rd, mr, mw, size, 1'b0, 1'b1);
      @(negedge clk);
      check({tag, " wb_valid"},     64'(wb_valid), 64'd1);
      check({tag, " wb_misalign"},  64'(wb_misalign), 64'd1);
      check({tag, " wb_reg_write"}, 64'(wb_reg_write), 64'd0);
      check({tag, " wb_rd"},        64'(wb_rd), 64'(rd));
      check({tag, " req_valid"},    64'(memif.req_valid), 64'd0);
      check({tag, " in_ready"},     64'(in_ready), 64'd1);
      @(negedge clk);
      check({tag, " pulse"},        64'(wb_valid), 64'd0);
      check({tag, " no req"},       64'(memif.req_valid), 64'd0);
   endtask

   task automatic do_mem(input string tag, input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic [1:0] size, input logic uns, input logic rw,
                         input logic [63:0] rdata, input int unsigned stall,
                         input logic [63:0] exp_req_addr, input logic exp_we,
                         input logic [7:0] exp_wstrb, input logic [63:0] exp_wdata,
                         input logic [63:0] exp_wb_data, input logic exp_rw);
      memif.req_ready = 1'b0;
      drive(addr, sdata, rd, mr, mw, size, uns, rw);
      @(negedge clk);
      check({tag, " req_valid"}, 64'(memif.req_valid), 64'd1);
      check({tag, " in_ready"},  64'(in_ready), 64'd0);
      check({tag, " req_addr"},  memif.req_addr, exp_req_addr);
      check({tag, " req_we"},    64'(memif.req_we), 64'(exp_we));
      if (exp_we) begin
         check({tag, " req_wstrb"}, 64'(memif.req_wstrb), 64'(exp_wstrb));
         check({tag, " req_wdata"}, memif.req_wdata, exp_wdata);
      end
      for (int unsigned i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, " stall req_valid"}, 64'(memif.req_valid), 64'd1);
         check({tag, " stall in_ready"},  64'(in_ready), 64'd0);
         check({tag, " stall req_addr"},  memif.req_addr, exp_req_addr);
         check({tag, " stall req_we"},    64'(memif.req_we), 64'(exp_we));
         check({tag, " stall wb_valid"},  64'(wb_valid), 64'd0);
      end
      memif.req_ready = 1'b1;
      @(posedge clk);
      #1;
      memif.req_ready  = 1'b0;
      memif.resp_valid = 1'b1;
      memif.resp_rdata = rdata;
      @(negedge clk);
      check({tag, " wait req_valid"}, 64'(memif.req_valid), 64'd0);
      check({tag, " wait in_ready"},  64'(in_ready), 64'd0);
      check({tag, " wait wb_valid"},  64'(wb_valid), 64'd0);
      @(posedge clk);
      #1 memif.resp_valid = 1'b0;
      @(negedge clk);
      check({tag, " wb_valid"},     64'(wb_valid), 64'd1);
      check({tag, " wb_data"},      wb_data, exp_wb_data);
      check({tag, " wb_rd"},        64'(wb_rd), 64'(rd));
      check({tag, " wb_reg_write"}, 64'(wb_reg_write), 64'(exp_rw));
      check({tag, " wb_misalign"},  64'(wb_misalign), 64'd0);
      check({tag, " in_ready"},     64'(in_ready), 64'd1);
      @(negedge clk);
      check({tag, " pulse"},        64'(wb_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset            = 1'b1;
      in_valid         = 1'b0;
      in_addr          = '0;
      in_store_data    = '0;
      in_mem_read      = 1'b0;
      in_mem_write     = 1'b0;
      in_size          = 2'd0;
      in_unsigned      = 1'b0;
      in_rd            = '0;
      in_reg_write     = 1'b0;
      memif.req_ready  = 1'b0;
      memif.resp_valid = 1'b0;
      memif.resp_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      do_alu("alu", 64'h1234, 5'd5, 1'b1);
      do_alu("alu2", 64'hDEAD_BEEF_0000_0007, 5'd31, 1'b0);

      do_mem("ldw_s", 64'h1004, 64'h0, 5'd7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 0, 64'h1000, 1'b0, 8'h00, 64'h0,
             64'hFFFF_FFFF_8000_0000, 1'b1);
      do_mem("ldw_u", 64'h1004, 64'h0, 5'd7, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1,
             64'h8000_0000_0000_0000, 0, 64'h1000, 1'b0, 8'h00, 64'h0,
             64'h0000_0000_8000_0000, 1'b1);
      do_mem("sth", 64'h2006, 64'hABCD, 5'd3, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1,
             64'h0, 0, 64'h2000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000,
             64'h0, 1'b0);
      do_mem("ldb_s", 64'h4007, 64'h0, 5'd9, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1,
             64'h8011_2233_4455_6677, 0, 64'h4000, 1'b0, 8'h00, 64'h0,
             64'hFFFF_FFFF_FFFF_FF80, 1'b1);
      do_mem("ldh_u", 64'h8002, 64'h0, 5'd10, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1,
             64'h0000_0000_F00D_0000, 0, 64'h8000, 1'b0, 8'h00, 64'h0,
             64'h0000_0000_0000_F00D, 1'b1);
      do_mem("ldd_u", 64'h5000, 64'h0, 5'd11, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1,
             64'h8123_4567_89AB_CDEF, 0, 64'h5000, 1'b0, 8'h00, 64'h0,
             64'h8123_4567_89AB_CDEF, 1'b1);
      do_mem("std", 64'h6000, 64'h1122_3344_5566_7788, 5'd1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1,
             64'h0, 0, 64'h6000, 1'b1, 8'hFF, 64'h1122_3344_5566_7788,
             64'h0, 1'b0);
      do_mem("stb", 64'h7003, 64'h1122_3344_5566_77A5, 5'd2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1,
             64'h0, 0, 64'h7000, 1'b1, 8'h08, 64'h4455_6677_A500_0000,
             64'h0, 1'b0);
      do_mem("rw_both", 64'h9000, 64'hFFFF, 5'd12, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1,
             64'h0000_0000_1234_5678, 0, 64'h9000, 1'b0, 8'h00, 64'h0,
             64'h0000_0000_1234_5678, 1'b1);

      do_misalign("mis_ldh", 64'h3001, 1'b1, 1'b0, 2'd1, 5'd4);
      do_misalign("mis_stw", 64'h3006, 1'b0, 1'b1, 2'd2, 5'd6);
      do_misalign("mis_ldd", 64'h3004, 1'b1, 1'b0, 2'd3, 5'd8);

      do_mem("bp", 64'h1004, 64'h0, 5'd13, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1,
             64'h8000_0000_0000_0000, 4, 64'h1000, 1'b0, 8'h00, 64'h0,
             64'h0000_0000_8000_0000, 1'b1);

      // Reset lands while the access waits for its response.
      memif.req_ready = 1'b1;
      drive(64'h0000_0000_0000_A008, 64'h0, 5'd14, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      memif.req_ready  = 1'b0;
      reset            = 1'b1;
      memif.resp_valid = 1'b1;
      memif.resp_rdata = 64'h5555_AAAA_5555_AAAA;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_wait");
      @(negedge clk);
      check("rst_wait late wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wait late req_valid", 64'(memif.req_valid), 64'd0);
      memif.resp_valid = 1'b0;

      do_alu("alu_after_rst", 64'h0000_0000_0000_0042, 5'd15, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
